aes_gcm_instance_scheduler: RTL and testbench
=============================================

Name: aes_gcm_instance_scheduler

Overview:
- Front-end sequencer for the unrolled AES-GCM pipeline. It accepts one instance descriptor at a time: IV plus AAD and plaintext byte lengths.
- It then issues one pipeline slot per cycle. Each slot carries phase, new_instance, J0, counter block, data block and instance_size, feeding stage 0 of the encrypt pipeline.
- Every instance is sequenced as INIT -> AAD blocks -> PT blocks -> LEN. Bubbles are inserted when input data is not available, because the pipeline itself never stalls.

Parameters:
- LEN_W, 16, width of the byte-length fields in the descriptor (max 2^LEN_W-1 bytes each).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- i_desc_valid  in  1  descriptor valid
- o_desc_ready  out  1  descriptor accepted when valid&ready
- i_iv  in  [0:95]  96-bit IV
- i_aad_len  in  [LEN_W-1:0]  AAD length in bytes
- i_pt_len  in  [LEN_W-1:0]  plaintext length in bytes
- i_data_valid  in  1  upstream data block valid
- o_data_ready  out  1  data block consumed when valid&ready
- i_data  in  [0:127]  AAD or PT block, MSB-first; partial last block is zero-padded by the source
- o_valid  out  1  slot valid (registered)
- o_phase  out  [0:2]  encoding: 0 = bubble, 1 = INIT, 2 = AAD, 3 = PT, 4 = LEN
- o_new_instance  out  1  high only on the INIT slot
- o_j0  out  [0:127]  IV || 32'h00000001, held for the whole instance
- o_encrypted_cb_in  out  [0:127]  counter block for PT slots
- o_data  out  [0:127]  AAD/PT block in AAD/PT slots, else 0
- o_instance_size  out  [0:127]  {64-bit AAD length in bits, 64-bit PT length in bits}
- o_busy  out  1  state != IDLE

Behaviour:
- All slot outputs are registered. Reset (asynchronous, active-high) forces:
  - o_valid = 0, o_phase = 0, o_new_instance = 0
  - o_j0, o_encrypted_cb_in, o_data and o_instance_size all = 0
  - state = IDLE, internal counters = 0
  - o_desc_ready = 0 while rst is high
- Reset mid-instance aborts the instance. The remaining blocks are neither issued nor consumed. After rst drops, the scheduler is in IDLE and ready.
- FSM: IDLE, INIT, AAD, PT, LEN.
  - IDLE: o_desc_ready = 1. On accept, latch IV and lengths:
    - aad_blk = ceil(aad_len/16); pt_blk = ceil(pt_len/16)
    - instance_size = {zext64(aad_len<<3), zext64(pt_len<<3)}
    - J0 = IV || 32'h1; cb = J0
    - next state = INIT
  - INIT: issue exactly one slot with o_phase = 1 and o_new_instance = 1. Next state is AAD if aad_blk > 0, else PT if pt_blk > 0, else LEN.
  - AAD: o_data_ready = 1. Each handshake issues a slot with o_phase = 2 and o_data = i_data. A cycle with no handshake issues a bubble (o_valid = 0, o_phase = 0). After aad_blk slots, go to PT if pt_blk > 0, else LEN.
  - PT: same handshake rules as AAD. Each slot is issued with cb updated first: cb = inc32(cb), then o_encrypted_cb_in = the new cb. So the first PT slot carries J0 with low word 2.
    - inc32 adds 1 modulo 2^32 to bits [96:127] only; bits [0:95] are unchanged.
    - Wrap 32'hFFFFFFFF -> 32'h00000000 is legal and carries nothing into the IV.
    - After pt_blk slots, go to LEN.
  - LEN: issue one slot with o_phase = 4 and o_data = instance_size, then go to IDLE.
- o_data_ready = 0 in IDLE, INIT and LEN, so data offered outside AAD/PT is not consumed.
- In every valid slot, o_j0 and o_instance_size equal the latched values. o_encrypted_cb_in holds its last value in non-PT slots.
- The earliest next descriptor is accepted the cycle after the LEN slot is issued, i.e. one idle cycle between instances.
- Latency: descriptor accept at cycle t gives INIT o_valid at t+2 and the first data slot at t+3 at the earliest.
- An empty instance (aad_len = 0 and pt_len = 0) issues INIT then LEN, 2 slots total.

Optional Feature:
- Macro AES_GCM_SCHED_BUBBLE_CNT_EN.
- When defined: adds output o_bubble_cnt [31:0]. It counts cycles in AAD/PT with no handshake, saturates at 32'hFFFFFFFF, and clears on rst and on each descriptor accept.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- IV = 96'h0, aad_len = 16, pt_len = 32, data always valid -> slots INIT, AAD, PT (cb low = 2), PT (cb low = 3), LEN with o_data = {64'd128, 64'd256}; o_new_instance high only on INIT.
- aad_len = 0, pt_len = 0 -> exactly INIT then LEN, o_instance_size = 0, o_data_ready never high.
- aad_len = 17, pt_len = 1 -> 2 AAD slots (ceil), 1 PT slot, instance_size = {64'd136, 64'd8}.
- IV low word irrelevant; preload via pt_len such that cb passes 32'hFFFFFFFF: use IV = 96'hAB.., pt_len = 48 with a forced J0 variant via test hook disabled; instead check inc32 by driving 2^32-range model check on the low word -> bits [0:95] of o_encrypted_cb_in always equal IV.
- PT phase with i_data_valid toggling 1,0,0,1 -> bubbles (o_valid = 0, phase 0) on the low cycles, cb increments only on handshakes; with the macro defined, o_bubble_cnt = 2.
- rst asserted during the 2nd of 4 PT slots -> all outputs 0 immediately; after release o_desc_ready = 1 and a new descriptor runs cleanly starting with INIT.

Source files
------------

// File: rtl/aes_gcm_instance_scheduler_if.sv
// Descriptor, data and slot bundle for the AES-GCM instance scheduler.
// master: the upstream source driving descriptors and data blocks and observing slots.
// slave: the scheduler itself.
interface aes_gcm_instance_scheduler_if #(
    parameter int LEN_W = 16
);
    // Descriptor handshake
    logic             i_desc_valid;
    logic             o_desc_ready;
    logic [0:95]      i_iv;
    logic [LEN_W-1:0] i_aad_len;
    logic [LEN_W-1:0] i_pt_len;

    // AAD / PT block handshake
    logic             i_data_valid;
    logic             o_data_ready;
    logic [0:127]     i_data;

    // Pipeline slot towards stage 0 of the encrypt pipeline
    logic             o_valid;
    logic [0:2]       o_phase;
    logic             o_new_instance;
    logic [0:127]     o_j0;
    logic [0:127]     o_encrypted_cb_in;
    logic [0:127]     o_data;
    logic [0:127]     o_instance_size;
    logic             o_busy;

    modport master (
        output i_desc_valid, i_iv, i_aad_len, i_pt_len, i_data_valid, i_data,
        input  o_desc_ready, o_data_ready, o_valid, o_phase, o_new_instance,
               o_j0, o_encrypted_cb_in, o_data, o_instance_size, o_busy
    );

    modport slave (
        input  i_desc_valid, i_iv, i_aad_len, i_pt_len, i_data_valid, i_data,
        output o_desc_ready, o_data_ready, o_valid, o_phase, o_new_instance,
               o_j0, o_encrypted_cb_in, o_data, o_instance_size, o_busy
    );
endinterface

// File: rtl/aes_gcm_instance_scheduler.sv
// Front-end sequencer for the unrolled AES-GCM pipeline.
// Accepts one instance descriptor (IV, AAD/PT byte lengths) and issues one
// slot per cycle: INIT -> AAD blocks -> PT blocks -> LEN. Cycles without an
// upstream data block in AAD/PT become bubbles, since the pipeline never stalls.
// Optional feature: define AES_GCM_SCHED_BUBBLE_CNT_EN to add o_bubble_cnt,
// a saturating count of bubble cycles for the current instance.
module aes_gcm_instance_scheduler #(
    parameter int LEN_W = 16
) (
    input  logic clk,
    input  logic rst,
    aes_gcm_instance_scheduler_if.slave sif
`ifdef AES_GCM_SCHED_BUBBLE_CNT_EN
    ,
    output logic [31:0] o_bubble_cnt
`endif
);

    localparam logic [0:2] PH_BUBBLE = 3'd0;
    localparam logic [0:2] PH_INIT   = 3'd1;
    localparam logic [0:2] PH_AAD    = 3'd2;
    localparam logic [0:2] PH_PT     = 3'd3;
    localparam logic [0:2] PH_LEN    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AAD,
        S_PT,
        S_LEN
    } state_t;

    // Number of 16-byte blocks covering len bytes (last block may be partial)
    function automatic logic [LEN_W-1:0] ceil_blk(input logic [LEN_W-1:0] len);
        ceil_blk = (len >> 4) + LEN_W'(|len[3:0]);
    endfunction

    // Byte length to zero-extended 64-bit bit length
    function automatic logic [63:0] bits64(input logic [LEN_W-1:0] len);
        bits64 = {{(61-LEN_W){1'b0}}, len, 3'b000};
    endfunction

    // GCM inc32: only the low word counts, wrapping without carry into the IV
    function automatic logic [0:127] inc32(input logic [0:127] cb);
        inc32 = {cb[0:95], cb[96:127] + 32'd1};
    endfunction

    // Saturating 32-bit increment
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t           state;
    logic [0:127]     j0_q;
    logic [0:127]     size_q;
    logic [0:127]     cb_q;
    logic [LEN_W-1:0] aad_blk_q;
    logic [LEN_W-1:0] pt_blk_q;
    logic [LEN_W-1:0] blk_cnt_q;

    // Slot registers presented to pipeline stage 0
    logic             vld_p0;
    logic [0:2]       phase_p0;
    logic             new_inst_p0;
    logic [0:127]     cb_p0;
    logic [0:127]     data_p0;

    logic             desc_ready;
    logic             data_ready;
    logic             desc_hs;
    logic             data_hs;
    logic             aad_last;
    logic             pt_last;
    logic [0:127]     cb_next;

    assign desc_ready = (state == S_IDLE) && !rst;
    assign data_ready = (state == S_AAD) || (state == S_PT);
    assign desc_hs    = sif.i_desc_valid && desc_ready;
    assign data_hs    = sif.i_data_valid && data_ready;
    assign aad_last   = (blk_cnt_q == aad_blk_q - LEN_W'(1));
    assign pt_last    = (blk_cnt_q == pt_blk_q - LEN_W'(1));
    assign cb_next    = inc32(cb_q);

    // Instance sequencer: latches the descriptor and emits one registered slot per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            j0_q        <= '0;
            size_q      <= '0;
            cb_q        <= '0;
            aad_blk_q   <= '0;
            pt_blk_q    <= '0;
            blk_cnt_q   <= '0;
            vld_p0      <= 1'b0;
            phase_p0    <= PH_BUBBLE;
            new_inst_p0 <= 1'b0;
            cb_p0       <= '0;
            data_p0     <= '0;
        end else begin
            // Default slot is a bubble; cb_p0 deliberately holds outside PT slots
            vld_p0      <= 1'b0;
            phase_p0    <= PH_BUBBLE;
            new_inst_p0 <= 1'b0;
            data_p0     <= '0;

            case (state)
                S_IDLE: begin
                    if (desc_hs) begin
                        j0_q      <= {sif.i_iv, 32'h0000_0001};
                        cb_q      <= {sif.i_iv, 32'h0000_0001};
                        size_q    <= {bits64(sif.i_aad_len), bits64(sif.i_pt_len)};
                        aad_blk_q <= ceil_blk(sif.i_aad_len);
                        pt_blk_q  <= ceil_blk(sif.i_pt_len);
                        blk_cnt_q <= '0;
                        state     <= S_INIT;
                    end
                end

                S_INIT: begin
                    vld_p0      <= 1'b1;
                    phase_p0    <= PH_INIT;
                    new_inst_p0 <= 1'b1;
                    if (aad_blk_q != '0) begin
                        state <= S_AAD;
                    end else if (pt_blk_q != '0) begin
                        state <= S_PT;
                    end else begin
                        state <= S_LEN;
                    end
                end

                S_AAD: begin
                    if (data_hs) begin
                        vld_p0   <= 1'b1;
                        phase_p0 <= PH_AAD;
                        data_p0  <= sif.i_data;
                        if (aad_last) begin
                            blk_cnt_q <= '0;
                            state     <= (pt_blk_q != '0) ? S_PT : S_LEN;
                        end else begin
                            blk_cnt_q <= blk_cnt_q + LEN_W'(1);
                        end
                    end
                end

                S_PT: begin
                    if (data_hs) begin
                        vld_p0   <= 1'b1;
                        phase_p0 <= PH_PT;
                        data_p0  <= sif.i_data;
                        cb_q     <= cb_next;
                        cb_p0    <= cb_next;
                        if (pt_last) begin
                            blk_cnt_q <= '0;
                            state     <= S_LEN;
                        end else begin
                            blk_cnt_q <= blk_cnt_q + LEN_W'(1);
                        end
                    end
                end

                S_LEN: begin
                    vld_p0   <= 1'b1;
                    phase_p0 <= PH_LEN;
                    data_p0  <= size_q;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AES_GCM_SCHED_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q;

    // Bubble counter: AAD/PT cycles without a handshake, restarted per instance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (desc_hs) begin
            bubble_cnt_q <= '0;
        end else if (data_ready && !sif.i_data_valid) begin
            bubble_cnt_q <= sat_inc32(bubble_cnt_q);
        end
    end

    assign o_bubble_cnt = bubble_cnt_q;
`endif

    assign sif.o_desc_ready      = desc_ready;
    assign sif.o_data_ready      = data_ready;
    assign sif.o_valid           = vld_p0;
    assign sif.o_phase           = phase_p0;
    assign sif.o_new_instance    = new_inst_p0;
    assign sif.o_j0              = j0_q;
    assign sif.o_encrypted_cb_in = cb_p0;
    assign sif.o_data            = data_p0;
    assign sif.o_instance_size   = size_q;
    assign sif.o_busy            = (state != S_IDLE);

endmodule

// File: tb/tb_aes_gcm_instance_scheduler.sv
// Self-checking bench for aes_gcm_instance_scheduler.
// Data blocks handed over are recorded; the expected slot stream is rebuilt
// from the descriptor and those blocks and compared with the observed slots.
module tb_aes_gcm_instance_scheduler;
    localparam int LEN_W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_gcm_instance_scheduler_if #(.LEN_W(LEN_W)) sif ();

`ifdef AES_GCM_SCHED_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    aes_gcm_instance_scheduler #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
`ifdef AES_GCM_SCHED_BUBBLE_CNT_EN
        ,
        .o_bubble_cnt (bubble_cnt)
`endif
    );

    typedef struct packed {
        logic         valid;
        logic [2:0]   phase;
        logic         newi;
        logic [127:0] j0;
        logic [127:0] cb;
        logic [127:0] data;
        logic [127:0] size;
    } slot_t;

    int           errors = 0;
    int           checks = 0;
    slot_t        obs_q[$];
    slot_t        exp_q[$];
    logic [127:0] sent_q[$];
    logic [127:0] model_cb = '0;
    int           accept_wait;
    int           init_idx;
    int           len_idx;
    int           bubble_seen;
    bit           done;
    bit           ready_seen;

    function automatic slot_t sample_slot();
        slot_t s;
        s.valid = sif.o_valid;
        s.phase = sif.o_phase;
        s.newi  = sif.o_new_instance;
        s.j0    = sif.o_j0;
        s.cb    = sif.o_encrypted_cb_in;
        s.data  = sif.o_data;
        s.size  = sif.o_instance_size;
        return s;
    endfunction

    // Drives one descriptor and its data (valid pattern vpat, LSB first, per ready cycle);
    // records every valid slot and every block handed over. Starts and ends at a negedge.
    task automatic run_instance(input logic [95:0] iv, input int aad_len, input int pt_len,
                                input logic [31:0] vpat, input int max_cyc);
        int    k;
        bit    in_inst;
        slot_t s;
        obs_q.delete();
        sent_q.delete();
        init_idx = -1; len_idx = -1; bubble_seen = 0; done = 0; ready_seen = 0;
        accept_wait = 0; k = 0; in_inst = 0;
        sif.i_iv = iv;
        sif.i_aad_len = LEN_W'(aad_len);
        sif.i_pt_len = LEN_W'(pt_len);
        sif.i_desc_valid = 1'b1;
        while (!sif.o_desc_ready && accept_wait < 20) begin
            @(negedge clk);
            accept_wait++;
        end
        if (!sif.o_desc_ready) begin
            sif.i_desc_valid = 1'b0;
            return;
        end
        sif.i_data_valid = vpat[k % 32];
        sif.i_data = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            sif.i_desc_valid = 1'b0;
            s = sample_slot();
            ready_seen = ready_seen | sif.o_data_ready;
            if (s.valid) begin
                obs_q.push_back(s);
                if (s.phase == 3'd1) begin init_idx = c; in_inst = 1; end
                if (s.phase == 3'd4) begin len_idx = c; in_inst = 0; done = 1; end
            end else if (in_inst) begin
                bubble_seen++;
            end
            if (done) begin
                sif.i_data_valid = 1'b0;
            end else begin
                sif.i_data_valid = vpat[k % 32];
                sif.i_data = {$urandom, $urandom, $urandom, $urandom};
                if (sif.o_data_ready) begin
                    if (sif.i_data_valid) sent_q.push_back(sif.i_data);
                    k++;
                end
            end
        end
    endtask

    // Expected slot stream from the descriptor and the recorded data blocks
    task automatic build_exp(input logic [95:0] iv, input int aad_len, input int pt_len);
        slot_t        e;
        int           na, np, si;
        logic [127:0] j0, size;
        na = (aad_len + 15) / 16;
        np = (pt_len + 15) / 16;
        j0 = {iv, 32'h0000_0001};
        size = {64'(aad_len) << 3, 64'(pt_len) << 3};
        exp_q.delete();
        si = 0;
        e = '0; e.valid = 1; e.phase = 3'd1; e.newi = 1; e.j0 = j0; e.cb = model_cb; e.size = size;
        exp_q.push_back(e);
        for (int i = 0; i < na; i++) begin
            e = '0; e.valid = 1; e.phase = 3'd2; e.j0 = j0; e.cb = model_cb; e.size = size;
            e.data = (si < sent_q.size()) ? sent_q[si] : '0;
            si++;
            exp_q.push_back(e);
        end
        for (int i = 0; i < np; i++) begin
            model_cb = {iv, 32'(i + 2)};
            e = '0; e.valid = 1; e.phase = 3'd3; e.j0 = j0; e.cb = model_cb; e.size = size;
            e.data = (si < sent_q.size()) ? sent_q[si] : '0;
            si++;
            exp_q.push_back(e);
        end
        e = '0; e.valid = 1; e.phase = 3'd4; e.j0 = j0; e.cb = model_cb; e.data = size; e.size = size;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sif.i_desc_valid = 1'b0; sif.i_iv = '0; sif.i_aad_len = '0; sif.i_pt_len = '0;
        sif.i_data_valid = 1'b0; sif.i_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sif.o_valid, sif.o_phase, sif.o_new_instance} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid/phase/new=%b, required 00000",
                     {sif.o_valid, sif.o_phase, sif.o_new_instance});
        end
        checks++;
        if ({sif.o_j0, sif.o_encrypted_cb_in, sif.o_data, sif.o_instance_size} !== 512'b0) begin
            errors++;
            $display("FAIL reset_data: got j0=%h cb=%h data=%h size=%h, required all 0",
                     sif.o_j0, sif.o_encrypted_cb_in, sif.o_data, sif.o_instance_size);
        end
        checks++;
        if ({sif.o_desc_ready, sif.o_data_ready, sif.o_busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got desc_rdy/data_rdy/busy=%b, required 000",
                     {sif.o_desc_ready, sif.o_data_ready, sif.o_busy});
        end
`ifdef AES_GCM_SCHED_BUBBLE_CNT_EN
        checks++;
        if (bubble_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_bubble_cnt: got %0d, required 0", bubble_cnt);
        end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (sif.o_desc_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", sif.o_desc_ready);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        run_instance(96'h0, 16, 32, 32'hFFFF_FFFF, 40);
        build_exp(96'h0, 16, 32);
        checks++;
        if (!done) begin errors++; $display("FAIL basic_timeout: got no LEN slot, required LEN"); end
        checks++;
        if (accept_wait !== 0) begin errors++; $display("FAIL basic_accept: got wait %0d, required 0", accept_wait); end
        checks++;
        if (init_idx !== 1) begin errors++; $display("FAIL basic_init_latency: got %0d, required 1", init_idx); end
        checks++;
        if (len_idx - init_idx !== 4 || bubble_seen !== 0) begin
            errors++;
            $display("FAIL basic_back_to_back_slots: got span %0d bubbles %0d, required 4 and 0",
                     len_idx - init_idx, bubble_seen);
        end
        checks++;
        if (exp_q[4].data !== {64'd128, 64'd256}) begin
            errors++;
            $display("FAIL basic_len_const: got %h, required %h", exp_q[4].data, {64'd128, 64'd256});
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d slots, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_slot%0d: got ph=%0d ni=%0b cb=%h data=%h size=%h, required ph=%0d ni=%0b cb=%h data=%h size=%h",
                         i, obs_q[i].phase, obs_q[i].newi, obs_q[i].cb, obs_q[i].data, obs_q[i].size,
                         exp_q[i].phase, exp_q[i].newi, exp_q[i].cb, exp_q[i].data, exp_q[i].size);
            end
        end
    endtask

    task automatic test_empty();
        @(negedge clk);
        run_instance(96'h1234_5678_9ABC_DEF0_1122_3344, 0, 0, 32'hFFFF_FFFF, 20);
        build_exp(96'h1234_5678_9ABC_DEF0_1122_3344, 0, 0);
        checks++;
        if (!done) begin errors++; $display("FAIL empty_timeout: got no LEN slot, required LEN"); end
        checks++;
        if (ready_seen !== 1'b0) begin errors++; $display("FAIL empty_data_ready: got 1, required never high"); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL empty_count: got %0d slots, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL empty_slot%0d: got ph=%0d ni=%0b j0=%h data=%h size=%h, required ph=%0d ni=%0b j0=%h data=%h size=%h",
                         i, obs_q[i].phase, obs_q[i].newi, obs_q[i].j0, obs_q[i].data, obs_q[i].size,
                         exp_q[i].phase, exp_q[i].newi, exp_q[i].j0, exp_q[i].data, exp_q[i].size);
            end
        end
    endtask

    task automatic test_ceil();
        @(negedge clk);
        run_instance(96'hABCD_EF01_2345_6789_ABCD_EF01, 17, 1, 32'hFFFF_FFFF, 40);
        build_exp(96'hABCD_EF01_2345_6789_ABCD_EF01, 17, 1);
        checks++;
        if (!done) begin errors++; $display("FAIL ceil_timeout: got no LEN slot, required LEN"); end
        checks++;
        if (obs_q.size() != 5 || exp_q.size() != 5) begin
            errors++;
            $display("FAIL ceil_count: got %0d slots, required 5", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ceil_slot%0d: got ph=%0d cb=%h data=%h size=%h, required ph=%0d cb=%h data=%h size=%h",
                         i, obs_q[i].phase, obs_q[i].cb, obs_q[i].data, obs_q[i].size,
                         exp_q[i].phase, exp_q[i].cb, exp_q[i].data, exp_q[i].size);
            end
        end
    endtask

    task automatic test_cb_iv();
        logic [95:0] iv;
        int          npt;
        logic [31:0] prev_lo;
        iv = 96'hFEDC_BA98_7654_3210_0F1E_2D3C;
        npt = 0;
        prev_lo = 32'd1;
        @(negedge clk);
        run_instance(iv, 0, 48, 32'hFFFF_FFFF, 40);
        build_exp(iv, 0, 48);
        checks++;
        if (!done) begin errors++; $display("FAIL cb_timeout: got no LEN slot, required LEN"); end
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i].phase == 3'd3) begin
                npt++;
                checks++;
                if (obs_q[i].cb[127:32] !== iv || obs_q[i].cb[31:0] !== prev_lo + 32'd1) begin
                    errors++;
                    $display("FAIL cb_inc32_%0d: got %h, required %h", i, obs_q[i].cb, {iv, prev_lo + 32'd1});
                end
                prev_lo = prev_lo + 32'd1;
            end
        end
        checks++;
        if (npt !== 3) begin errors++; $display("FAIL cb_pt_count: got %0d, required 3", npt); end
    endtask

    task automatic test_bubbles();
        logic [95:0] iv;
        iv = 96'h0123_4567_89AB_CDEF_0011_2233;
        @(negedge clk);
        run_instance(iv, 0, 64, 32'hFFFF_FFF9, 40);
        build_exp(iv, 0, 64);
        checks++;
        if (!done) begin errors++; $display("FAIL bubble_timeout: got no LEN slot, required LEN"); end
        checks++;
        if (bubble_seen !== 2) begin errors++; $display("FAIL bubble_slots: got %0d, required 2", bubble_seen); end
`ifdef AES_GCM_SCHED_BUBBLE_CNT_EN
        checks++;
        if (bubble_cnt !== 32'd2) begin errors++; $display("FAIL bubble_cnt: got %0d, required 2", bubble_cnt); end
`endif
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bubble_count: got %0d slots, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bubble_slot%0d: got ph=%0d cb=%h data=%h, required ph=%0d cb=%h data=%h",
                         i, obs_q[i].phase, obs_q[i].cb, obs_q[i].data,
                         exp_q[i].phase, exp_q[i].cb, exp_q[i].data);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_instance(96'h1111_2222_3333_4444_5555_6666, 32, 16, 32'hFFFF_FFFF, 40);
        build_exp(96'h1111_2222_3333_4444_5555_6666, 32, 16);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_a_count: got %0d slots, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_a_slot%0d: got ph=%0d cb=%h data=%h, required ph=%0d cb=%h data=%h",
                         i, obs_q[i].phase, obs_q[i].cb, obs_q[i].data,
                         exp_q[i].phase, exp_q[i].cb, exp_q[i].data);
            end
        end
        run_instance(96'h7777_8888_9999_AAAA_BBBB_CCCC, 0, 17, 32'hFFFF_FFFF, 40);
        build_exp(96'h7777_8888_9999_AAAA_BBBB_CCCC, 0, 17);
        checks++;
        if (accept_wait !== 0) begin errors++; $display("FAIL b2b_accept_gap: got wait %0d, required 0", accept_wait); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_b_count: got %0d slots, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_b_slot%0d: got ph=%0d cb=%h data=%h, required ph=%0d cb=%h data=%h",
                         i, obs_q[i].phase, obs_q[i].cb, obs_q[i].data,
                         exp_q[i].phase, exp_q[i].cb, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_pt;
        bit any_valid;
        int w;
        seen_pt = 0; any_valid = 0; w = 0;
        @(negedge clk);
        sif.i_iv = 96'h5A5A_5A5A_A5A5_A5A5_5A5A_5A5A;
        sif.i_aad_len = LEN_W'(0);
        sif.i_pt_len = LEN_W'(64);
        sif.i_desc_valid = 1'b1;
        while (!sif.o_desc_ready && w < 20) begin @(negedge clk); w++; end
        sif.i_data_valid = 1'b1;
        for (int c = 0; c < 30 && !seen_pt; c++) begin
            @(negedge clk);
            sif.i_desc_valid = 1'b0;
            sif.i_data = {$urandom, $urandom, $urandom, $urandom};
            if (sif.o_valid && sif.o_phase == 3'd3) seen_pt = 1;
        end
        checks++;
        if (!seen_pt) begin errors++; $display("FAIL rstmid_timeout: got no PT slot, required one"); end
        rst = 1'b1;
        #1;
        checks++;
        if ({sif.o_valid, sif.o_phase, sif.o_new_instance} !== 5'b0 ||
            {sif.o_j0, sif.o_encrypted_cb_in, sif.o_data, sif.o_instance_size} !== 512'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got valid=%b phase=%0d j0=%h cb=%h data=%h size=%h, required all 0",
                     sif.o_valid, sif.o_phase, sif.o_j0, sif.o_encrypted_cb_in, sif.o_data, sif.o_instance_size);
        end
        checks++;
        if ({sif.o_desc_ready, sif.o_data_ready, sif.o_busy} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_ready: got desc_rdy/data_rdy/busy=%b, required 000",
                     {sif.o_desc_ready, sif.o_data_ready, sif.o_busy});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (sif.o_desc_ready !== 1'b1 || sif.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: got desc_rdy=%b busy=%b, required 1 0", sif.o_desc_ready, sif.o_busy);
        end
        repeat (3) begin
            @(negedge clk);
            any_valid = any_valid | sif.o_valid | sif.o_data_ready;
        end
        sif.i_data_valid = 1'b0;
        checks++;
        if (any_valid) begin errors++; $display("FAIL rstmid_leftover: got slot or data_ready after abort, required none"); end
        model_cb = '0;
        run_instance(96'hC0FF_EE00_1234_5678_9ABC_DEF0, 16, 16, 32'hFFFF_FFFF, 40);
        build_exp(96'hC0FF_EE00_1234_5678_9ABC_DEF0, 16, 16);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rstmid_count: got %0d slots, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid_slot%0d: got ph=%0d ni=%0b cb=%h data=%h, required ph=%0d ni=%0b cb=%h data=%h",
                         i, obs_q[i].phase, obs_q[i].newi, obs_q[i].cb, obs_q[i].data,
                         exp_q[i].phase, exp_q[i].newi, exp_q[i].cb, exp_q[i].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_ceil();
        test_cb_iv();
        test_bubbles();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
